viterbi_traceback: RTL and testbench

- Survivor-memory and traceback stage of the K=3 (4-state) rate-1/2 Viterbi decoder. Sits directly downstream of the four add-compare-select units.
- Each trellis step, it stores the 4-bit vector of ACS selection bits for one fixed-length frame.
- At frame end it traces back from a supplied final state, then emits the decoded bits in forward (time) order.
- Trellis convention: next_state = {in_bit, cur_state[1]}. Predecessor of state s is {s[0], sel[s]}. The decoded bit for the step that landed in state s is s[1].

---
 rtl/viterbi_traceback.sv | 140 ++++++++++++++
 tb/tb_viterbi_traceback.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// Survivor memory and traceback for a K=3 (4-state) Viterbi decoder.
// Stores one frame of ACS decisions, traces back from the final state, then emits bits in time order.
module viterbi_traceback #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid_i,
    input  logic [3:0] dec_sel_i,
    input  logic [1:0] end_state_i,
    output logic       dec_ready_o,
    output logic       bit_o,
    output logic       bit_valid_o,
    output logic       frame_done_o
);

    typedef enum logic [1:0] {
        ST_WRITE,
        ST_TRACE,
        ST_OUTPUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] wcnt_reg;
    logic [CNT_W-1:0] idx_reg;
    logic [CNT_W-1:0] ocnt_reg;
    logic [1:0]       tb_state_reg;

    logic [3:0] surv_mem [FRAME_LEN];
    logic       bit_mem  [FRAME_LEN];

    logic       accept;
    logic       write_last;
    logic [3:0] surv_word;
    logic       surv_bit;

    assign accept     = dec_valid_i && (state_reg == ST_WRITE);
    assign write_last = accept && (wcnt_reg == LAST_IDX);
    // Single-cycle traceback step needs the survivor word in the same cycle.
    assign surv_word  = surv_mem[idx_reg];
    assign surv_bit   = surv_word[tb_state_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_WRITE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        dec_ready_o = 1'b0;
        case (state_reg)
            ST_WRITE: begin
                dec_ready_o = 1'b1;
                if (write_last) begin
                    state_next = ST_TRACE;
                end
            end
            ST_TRACE: begin
                if (idx_reg == '0) begin
                    state_next = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (ocnt_reg == LAST_IDX) begin
                    state_next = ST_WRITE;
                end
            end
            default: begin
                state_next = ST_WRITE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_reg     <= '0;
            idx_reg      <= '0;
            ocnt_reg     <= '0;
            tb_state_reg <= 2'b00;
            bit_o        <= 1'b0;
            bit_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            bit_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
            case (state_reg)
                ST_WRITE: begin
                    if (accept) begin
                        if (write_last) begin
                            wcnt_reg     <= '0;
                            tb_state_reg <= end_state_i;
                            idx_reg      <= LAST_IDX;
                        end else begin
                            wcnt_reg <= wcnt_reg + 1'b1;
                        end
                    end
                end
                ST_TRACE: begin
                    // Predecessor of s is {s[0], sel[s]}.
                    tb_state_reg <= {tb_state_reg[0], surv_bit};
                    if (idx_reg == '0) begin
                        ocnt_reg <= '0;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    bit_o       <= bit_mem[ocnt_reg];
                    bit_valid_o <= 1'b1;
                    if (ocnt_reg == LAST_IDX) begin
                        frame_done_o <= 1'b1;
                        ocnt_reg     <= '0;
                    end else begin
                        ocnt_reg <= ocnt_reg + 1'b1;
                    end
                end
                default: begin
                    ocnt_reg <= '0;
                end
            endcase
        end
    end

    // Storage arrays carry no reset so they map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            surv_mem[wcnt_reg] <= dec_sel_i;
        end
        if (state_reg == ST_TRACE) begin
            bit_mem[idx_reg] <= tb_state_reg[1];
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: a 4-step and an 8-step instance driven from a frame table.
`timescale 1ns/1ps
module tb_viterbi_traceback;

    logic       clk;
    logic       rst;
    logic       dv  [2];
    logic [3:0] ds  [2];
    logic [1:0] de  [2];
    logic       rdy [2];
    logic       bo  [2];
    logic       bv  [2];
    logic       fd  [2];

    int total;
    int bad;

    viterbi_traceback #(.FRAME_LEN(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .dec_valid_i  (dv[0]),
        .dec_sel_i    (ds[0]),
        .end_state_i  (de[0]),
        .dec_ready_o  (rdy[0]),
        .bit_o        (bo[0]),
        .bit_valid_o  (bv[0]),
        .frame_done_o (fd[0])
    );

    viterbi_traceback #(.FRAME_LEN(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .dec_valid_i  (dv[1]),
        .dec_sel_i    (ds[1]),
        .end_state_i  (de[1]),
        .dec_ready_o  (rdy[1]),
        .bit_o        (bo[1]),
        .bit_valid_o  (bv[1]),
        .frame_done_o (fd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          d;
        int          n;
        logic [31:0] sels;
        logic [31:0] care;
        logic [1:0]  es;
        int          gap;
        bit          junk;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Starts at a negedge; returns at the negedge right after the last accept edge.
    task automatic send_frame(input int d, input int n, input logic [31:0] sels,
                              input logic [1:0] e, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    dv[d] = 1'b0;
                    ds[d] = 4'($urandom);
                    @(negedge clk);
                end
            end
            chk("ready_in_write", {31'b0, rdy[d]}, 32'd1);
            dv[d] = 1'b1;
            ds[d] = sels[4*i +: 4];
            de[d] = (i == n - 1) ? e : 2'($urandom);
            @(negedge clk);
            if (i == 0) begin
                chk("valid_idle_in_write", {31'b0, bv[d]}, 32'd0);
                chk("done_idle_in_write", {31'b0, fd[d]}, 32'd0);
            end
        end
        dv[d] = 1'b0;
    endtask

    task automatic drive_junk(input int d, input bit junk);
        dv[d] = junk;
        ds[d] = 4'($urandom);
        de[d] = 2'($urandom);
    endtask

    task automatic check_frame(input int d, input int n, input logic [7:0] exp,
                               input bit junk, input int id);
        int         k;
        bit         found;
        logic [7:0] got;
        k     = 0;
        found = 1'b0;
        got   = '0;
        chk("ready_low_after_last", {31'b0, rdy[d]}, 32'd0);
        drive_junk(d, junk);
        while (!found && k < 3 * n) begin
            @(negedge clk);
            k++;
            if (bv[d]) begin
                found = 1'b1;
            end else begin
                chk("ready_low_window", {31'b0, rdy[d]}, 32'd0);
                chk("done_low_before_out", {31'b0, fd[d]}, 32'd0);
                drive_junk(d, junk);
            end
        end
        if (!found) begin
            chk("first_valid_timeout", 32'd0, 32'd1);
            dv[d] = 1'b0;
            return;
        end
        chk("first_valid_latency", k, n + 1);
        for (int j = 0; j < n; j++) begin
            got[j] = bo[d];
            chk("bit_value", {31'b0, bo[d]}, {31'b0, exp[j]});
            chk("bit_valid", {31'b0, bv[d]}, 32'd1);
            chk("frame_done", {31'b0, fd[d]}, (j == n - 1) ? 32'd1 : 32'd0);
            chk("ready_during_out", {31'b0, rdy[d]}, (j == n - 1) ? 32'd1 : 32'd0);
            if (j < n - 1) begin
                drive_junk(d, junk);
                @(negedge clk);
            end
        end
        dv[d] = 1'b0;
        $display("frame %0d: len=%0d latency=%0d bits=%b expected=%b", id, n, k, got, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sv;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            dv[d] = 1'b0;
            ds[d] = 4'h0;
            de[d] = 2'b00;
        end

        // basic 4-step: bits 1,0,1,1
        tbl[0] = '{0, 4, 32'h0000_0400, 32'hFFFF_FFFF, 2'b11, 0, 1'b0, 8'h0D};
        // same path, unused select bits randomized
        tbl[1] = '{0, 4, 32'h0000_0400, 32'h0000_8424, 2'b11, 0, 1'b0, 8'h0D};
        // bits 0,1,1,0 with junk valid during trace/output
        tbl[2] = '{0, 4, 32'h0000_27BE, 32'hFFFF_FFFF, 2'b01, 0, 1'b1, 8'h06};
        // basic with 3 idle cycles between decisions
        tbl[3] = '{0, 4, 32'h0000_0400, 32'hFFFF_FFFF, 2'b11, 3, 1'b0, 8'h0D};
        // 8-step all-zero path
        tbl[4] = '{1, 8, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 0, 1'b0, 8'h00};
        // 8-step bits 1,1,0,1,0,0,1,0 back to back
        tbl[5] = '{1, 8, 32'hDB1D_427B, 32'hFFFF_FFFF, 2'b01, 0, 1'b0, 8'h4B};
        tbl[6] = '{1, 8, 32'hDB1D_427B, 32'hFFFF_FFFF, 2'b01, 0, 1'b1, 8'h4B};
        tbl[7] = '{1, 8, 32'h0000_0000, 32'hFFFF_FFFF, 2'b00, 1, 1'b0, 8'h00};

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", {31'b0, rdy[d]}, 32'd1);
            chk("reset_bit", {31'b0, bo[d]}, 32'd0);
            chk("reset_valid", {31'b0, bv[d]}, 32'd0);
            chk("reset_done", {31'b0, fd[d]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            sv = (tbl[i].sels & tbl[i].care) | ($urandom & ~tbl[i].care);
            send_frame(tbl[i].d, tbl[i].n, sv, tbl[i].es, tbl[i].gap);
            check_frame(tbl[i].d, tbl[i].n, tbl[i].exp, tbl[i].junk, i);
        end

        // Reset during TRACE on the 4-step instance; its last emitted bit was 1.
        send_frame(0, 4, 32'h0000_27BE, 2'b01, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_ready", {31'b0, rdy[0]}, 32'd1);
        chk("midreset_bit", {31'b0, bo[0]}, 32'd0);
        chk("midreset_valid", {31'b0, bv[0]}, 32'd0);
        chk("midreset_done", {31'b0, fd[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("no_bits_after_abort", {30'b0, bv[0], fd[0]}, 32'd0);
            chk("ready_after_abort", {31'b0, rdy[0]}, 32'd1);
        end
        send_frame(0, 4, 32'h0000_0400, 2'b11, 0);
        check_frame(0, 4, 8'h0D, 1'b0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
